// File: rtl/rhd_pkg.sv
// Shared constants, FSM state type and lane helper for the RHD frame packer.
package rhd_pkg;

  localparam logic [15:0] RHD_MAGIC       = 16'hA5C3;
  localparam int          RHD_FRAME_SLOTS = 35;
  localparam int          RHD_NUM_LANES   = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } pack_state_e;

  // Bit offset of stream word k, which carries lane 2k in its low half and lane 2k+1 in its high half.
  function automatic int unsigned lane_pair_lsb(input int unsigned k);
    return 32 * k;
  endfunction

endpackage

// File: rtl/rhd_slot_buffer.sv
// One-deep holding register for a captured slot, with busy flag and stream-word select mux.
module rhd_slot_buffer
  import rhd_pkg::*;
#(
  parameter int NUM_LANES = RHD_NUM_LANES,
  parameter int WIDX      = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    load,
  input  logic                    done,
  input  logic [16*NUM_LANES-1:0] load_data,
  input  logic [7:0]              load_channel,
  input  logic [WIDX-1:0]         word_sel,
  output logic                    busy,
  output logic [7:0]              channel,
  output logic [31:0]             word
);

  logic [16*NUM_LANES-1:0] data_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q  <= '0;
      channel <= '0;
      busy    <= 1'b0;
    end else begin
      if (load) begin
        data_q  <= load_data;
        channel <= load_channel;
      end
      if (load) busy <= 1'b1;
      else if (done) busy <= 1'b0;
    end
  end

  always_comb begin
    word = '0;
    for (int k = 0; k < NUM_LANES / 2; k++) begin
      if (word_sel == WIDX'(k)) word = data_q[lane_pair_lsb(k) +: 32];
    end
  end

endmodule

// File: rtl/rhd_frame_packer.sv
// Packs RHD slot captures into a 32-bit valid/ready stream: header per frame, lane pairs per slot.
// state  | meaning
// IDLE   | waiting for a slot; acceptance and channel sequencing decided here
// HEADER | presenting {MAGIC, frame_count}
// DATA   | presenting lane-pair words of the held slot
module rhd_frame_packer
  import rhd_pkg::*;
#(
  parameter int          NUM_LANES   = RHD_NUM_LANES,
  parameter int          FRAME_SLOTS = RHD_FRAME_SLOTS,
  parameter logic [15:0] MAGIC       = RHD_MAGIC
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    enable,
  input  logic                    s_valid,
  input  logic [7:0]              s_channel,
  input  logic [16*NUM_LANES-1:0] s_data,
  output logic [31:0]             m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    overflow,
  output logic                    seq_error,
  input  logic                    clear_flags,
  output logic [15:0]             drop_count,
  output logic [15:0]             frame_count
);

  localparam int              WIDX      = (NUM_LANES > 2) ? $clog2(NUM_LANES / 2) : 1;
  localparam logic [WIDX-1:0] LAST_WORD = WIDX'(NUM_LANES / 2 - 1);
  localparam logic [7:0]      LAST_CH   = 8'(FRAME_SLOTS - 1);

  pack_state_e     state_q, state_d;
  logic [WIDX-1:0] widx_q, widx_d, widx_inc, word_sel;
  logic            synced_q, synced_d;
  logic [7:0]      expected_q, expected_d;
  logic [15:0]     frame_count_d;
  logic [31:0]     m_data_d;
  logic            m_valid_d, m_last_d;
  logic            load, done, busy, seq_evt, ovf_evt, drop_evt;
  logic [7:0]      buf_channel;
  logic [31:0]     buf_word;

  rhd_slot_buffer #(
    .NUM_LANES (NUM_LANES),
    .WIDX      (WIDX)
  ) u_slot_buffer (
    .clk          (clk),
    .rstn         (rstn),
    .load         (load),
    .done         (done),
    .load_data    (s_data),
    .load_channel (s_channel),
    .word_sel     (word_sel),
    .busy         (busy),
    .channel      (buf_channel),
    .word         (buf_word)
  );

  always_comb begin
    state_d       = state_q;
    widx_d        = widx_q;
    synced_d      = synced_q;
    expected_d    = expected_q;
    frame_count_d = frame_count;
    m_data_d      = m_data;
    m_valid_d     = m_valid;
    m_last_d      = m_last;
    word_sel      = widx_q;
    widx_inc      = widx_q + 1'b1;
    load          = 1'b0;
    done          = 1'b0;
    seq_evt       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!enable) begin
          synced_d = 1'b0;
        end else if (s_valid) begin
          seq_evt = synced_q && (s_channel != expected_q);
          // Channel 0 always (re)starts a frame; anything else needs an unbroken sequence.
          if ((s_channel == 8'd0) || (synced_q && !seq_evt)) begin
            load      = 1'b1;
            synced_d  = 1'b1;
            m_valid_d = 1'b1;
            widx_d    = '0;
            if (s_channel == 8'd0) begin
              state_d  = ST_HEADER;
              m_data_d = {MAGIC, frame_count};
              m_last_d = 1'b0;
            end else begin
              state_d  = ST_DATA;
              m_data_d = s_data[31:0];
              m_last_d = (LAST_WORD == '0) && (s_channel == LAST_CH);
            end
          end else begin
            synced_d = 1'b0;
          end
        end
      end
      ST_HEADER: begin
        if (m_ready) begin
          frame_count_d = frame_count + 16'd1;
          state_d       = ST_DATA;
          widx_d        = '0;
          word_sel      = '0;
          m_data_d      = buf_word;
          m_last_d      = (LAST_WORD == '0) && (buf_channel == LAST_CH);
        end
      end
      ST_DATA: begin
        if (m_ready) begin
          if (widx_q == LAST_WORD) begin
            done       = 1'b1;
            state_d    = ST_IDLE;
            m_valid_d  = 1'b0;
            m_last_d   = 1'b0;
            expected_d = (buf_channel == LAST_CH) ? 8'd0 : buf_channel + 8'd1;
          end else begin
            widx_d   = widx_inc;
            word_sel = widx_inc;
            m_data_d = buf_word;
            m_last_d = (widx_inc == LAST_WORD) && (buf_channel == LAST_CH);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      widx_q      <= '0;
      synced_q    <= 1'b0;
      expected_q  <= '0;
      frame_count <= '0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      synced_q    <= synced_d;
      expected_q  <= expected_d;
      frame_count <= frame_count_d;
      m_data      <= m_data_d;
      m_valid     <= m_valid_d;
      m_last      <= m_last_d;
    end
  end

  assign ovf_evt  = s_valid && busy;
  assign drop_evt = ovf_evt || seq_evt;

  // A clear coinciding with a drop leaves that drop counted but the flags low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow   <= 1'b0;
      seq_error  <= 1'b0;
      drop_count <= '0;
    end else if (clear_flags) begin
      overflow   <= 1'b0;
      seq_error  <= 1'b0;
      drop_count <= drop_evt ? 16'd1 : 16'd0;
    end else begin
      if (ovf_evt) overflow <= 1'b1;
      if (seq_evt) seq_error <= 1'b1;
      if (drop_evt && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_rhd_frame_packer.sv
// Self-checking bench for rhd_frame_packer: directed table, corner sequences and random slots vs a queue model.
module tb_rhd_frame_packer;

  localparam int          NL    = 32;
  localparam int          FS    = 35;
  localparam logic [15:0] MAGIC = 16'hA5C3;

  logic            clk = 1'b0;
  logic            rstn, enable, s_valid, m_ready, clear_flags;
  logic [7:0]      s_channel;
  logic [16*NL-1:0] s_data;
  logic [31:0]     m_data;
  logic            m_valid, m_last, overflow, seq_error;
  logic [15:0]     drop_count, frame_count;

  always #5 clk = ~clk;

  rhd_frame_packer dut (
    .clk         (clk),
    .rstn        (rstn),
    .enable      (enable),
    .s_valid     (s_valid),
    .s_channel   (s_channel),
    .s_data      (s_data),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .overflow    (overflow),
    .seq_error   (seq_error),
    .clear_flags (clear_flags),
    .drop_count  (drop_count),
    .frame_count (frame_count)
  );

  typedef struct {
    logic        en;
    int          ch;
    int          exp_words;
    logic [31:0] exp_first;
    logic        exp_seq;
    logic [15:0] exp_drop;
    logic [15:0] exp_fc;
  } vec_t;

  vec_t         vecs [10];
  int           n_cmp = 0;
  int           n_fail = 0;
  logic [32:0]  got [$];
  logic [32:0]  exp_q [$];
  int           mon_words = 0;
  int           last_q [$];
  logic [15:0]  cur_lanes [NL];
  bit           rand_ready = 1'b0;

  // Reference model state
  bit           m_synced;
  int           m_exp;
  logic [15:0]  m_fc;
  logic [15:0]  m_drop;
  bit           m_ovf, m_seq;

  always @(negedge clk) begin
    if (rstn && m_valid && m_ready) begin
      got.push_back({m_last, m_data});
      mon_words++;
      if (m_last) last_q.push_back(mon_words);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, actual still running, required done");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic fill_pattern(input int ch);
    for (int l = 0; l < NL; l++) cur_lanes[l] = 16'((ch << 8) + l);
  endtask

  task automatic fill_random();
    for (int l = 0; l < NL; l++) cur_lanes[l] = 16'($urandom);
  endtask

  task automatic send_slot(input int ch);
    for (int l = 0; l < NL; l++) s_data[16*l +: 16] = cur_lanes[l];
    s_channel = 8'(ch);
    s_valid   = 1'b1;
    tick();
    s_valid   = 1'b0;
  endtask

  task automatic model_reset();
    m_synced = 1'b0;
    m_exp    = 0;
    m_fc     = '0;
    m_drop   = '0;
    m_ovf    = 1'b0;
    m_seq    = 1'b0;
    got.delete();
    exp_q.delete();
    last_q.delete();
    mon_words = 0;
  endtask

  // Frame rules applied to one slot arriving while the packer is idle.
  task automatic model_slot(input bit en, input int ch);
    bit seq;
    if (!en) begin
      m_synced = 1'b0;
      return;
    end
    seq = m_synced && (ch != m_exp);
    if (seq) begin
      m_seq    = 1'b1;
      m_synced = 1'b0;
      if (m_drop != 16'hFFFF) m_drop++;
    end
    if (ch == 0 || m_synced) begin
      if (ch == 0) begin
        exp_q.push_back({1'b0, MAGIC, m_fc});
        m_fc++;
      end
      for (int k = 0; k < NL / 2; k++)
        exp_q.push_back({(k == NL / 2 - 1) && (ch == FS - 1), cur_lanes[2*k+1], cur_lanes[2*k]});
      m_synced = 1'b1;
      m_exp    = (ch + 1) % FS;
    end
  endtask

  task automatic hw_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic do_clear();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    m_ovf  = 1'b0;
    m_seq  = 1'b0;
    m_drop = '0;
  endtask

  task automatic drain_compare(input string name);
    int n = 0;
    while (got.size() < exp_q.size() && n < 3000) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check({name, " word count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("%s word %0d", name, i), 64'(got[i]), 64'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int ch, idx;
    bit en;
    rstn = 1'b0; enable = 1'b0; s_valid = 1'b0; s_channel = '0; s_data = '0;
    m_ready = 1'b0; clear_flags = 1'b0;
    model_reset();

    // en, ch, words, first word, seq_error, drop_count, frame_count after the slot
    vecs[0] = '{1'b0, 0,  0,  32'h0,         1'b0, 16'd0, 16'd0};
    vecs[1] = '{1'b1, 7,  0,  32'h0,         1'b0, 16'd0, 16'd0};
    vecs[2] = '{1'b1, 0,  17, 32'hA5C3_0000, 1'b0, 16'd0, 16'd1};
    vecs[3] = '{1'b1, 1,  16, 32'h0101_0100, 1'b0, 16'd0, 16'd1};
    vecs[4] = '{1'b1, 3,  0,  32'h0,         1'b1, 16'd1, 16'd1};
    vecs[5] = '{1'b1, 2,  0,  32'h0,         1'b1, 16'd1, 16'd1};
    vecs[6] = '{1'b1, 0,  17, 32'hA5C3_0001, 1'b1, 16'd1, 16'd2};
    vecs[7] = '{1'b1, 1,  16, 32'h0101_0100, 1'b1, 16'd1, 16'd2};
    vecs[8] = '{1'b1, 40, 0,  32'h0,         1'b1, 16'd2, 16'd2};
    vecs[9] = '{1'b1, 0,  17, 32'hA5C3_0002, 1'b1, 16'd2, 16'd3};

    repeat (2) @(posedge clk);
    #1;
    check("reset m_valid", 64'(m_valid), 64'(0));
    check("reset m_data", 64'(m_data), 64'(0));
    check("reset m_last", 64'(m_last), 64'(0));
    check("reset overflow", 64'(overflow), 64'(0));
    check("reset seq_error", 64'(seq_error), 64'(0));
    check("reset drop_count", 64'(drop_count), 64'(0));
    check("reset frame_count", 64'(frame_count), 64'(0));
    rstn = 1'b1;
    m_ready = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      enable = vecs[i].en;
      tick();
      got.delete();
      fill_pattern(vecs[i].ch);
      send_slot(vecs[i].ch);
      repeat (25) tick();
      check($sformatf("vec%0d words", i), 64'(got.size()), 64'(vecs[i].exp_words));
      if (vecs[i].exp_words > 0 && got.size() > 0)
        check($sformatf("vec%0d first word", i), 64'(got[0][31:0]), 64'(vecs[i].exp_first));
      check($sformatf("vec%0d seq_error", i), 64'(seq_error), 64'(vecs[i].exp_seq));
      check($sformatf("vec%0d drop_count", i), 64'(drop_count), 64'(vecs[i].exp_drop));
      check($sformatf("vec%0d frame_count", i), 64'(frame_count), 64'(vecs[i].exp_fc));
      check($sformatf("vec%0d idle m_valid", i), 64'(m_valid), 64'(0));
    end

    // Full frame, channels 0..34, always ready
    hw_reset();
    enable = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < FS; c++) begin
      fill_pattern(c);
      model_slot(1'b1, c);
      send_slot(c);
      if (c == 0) begin
        repeat (20) tick();
        check("frame ch0 words", 64'(got.size()), 64'(17));
        if (got.size() >= 2) begin
          check("frame header", 64'(got[0]), 64'({1'b0, 32'hA5C3_0000}));
          check("frame ch0 word0", 64'(got[1]), 64'({1'b0, 32'h0001_0000}));
        end
      end
      drain_compare($sformatf("frame ch%0d", c));
    end
    check("frame total words", 64'(mon_words), 64'(561));
    check("frame m_last count", 64'(last_q.size()), 64'(1));
    if (last_q.size() > 0) check("frame m_last position", 64'(last_q[0]), 64'(561));

    // Backpressure mid-slot
    fill_pattern(0);
    model_slot(1'b1, 0);
    send_slot(0);
    repeat (4) tick();
    m_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      idx = got.size();
      check($sformatf("stall%0d m_valid", s), 64'(m_valid), 64'(1));
      if (idx < exp_q.size())
        check($sformatf("stall%0d m_data", s), 64'(m_data), 64'(exp_q[idx][31:0]));
    end
    m_ready = 1'b1;
    drain_compare("stall");

    // Overflow while busy
    do_clear();
    m_ready = 1'b0;
    fill_pattern(1);
    model_slot(1'b1, 1);
    send_slot(1);
    tick();
    s_data = {16{32'hDEAD_BEEF}};
    s_channel = 8'd2;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    m_ovf = 1'b1;
    m_drop++;
    check("ovf overflow", 64'(overflow), 64'(m_ovf));
    check("ovf drop_count", 64'(drop_count), 64'(m_drop));
    check("ovf seq_error", 64'(seq_error), 64'(m_seq));
    m_ready = 1'b1;
    drain_compare("ovf slot");

    // Clear coinciding with an overflow drop
    m_ready = 1'b0;
    fill_pattern(2);
    model_slot(1'b1, 2);
    send_slot(2);
    tick();
    s_channel = 8'd3;
    s_valid = 1'b1;
    clear_flags = 1'b1;
    tick();
    s_valid = 1'b0;
    clear_flags = 1'b0;
    m_ovf = 1'b0;
    m_seq = 1'b0;
    m_drop = 16'd1;
    check("clear+drop overflow", 64'(overflow), 64'(m_ovf));
    check("clear+drop drop_count", 64'(drop_count), 64'(m_drop));
    m_ready = 1'b1;
    drain_compare("clear slot");

    // Asynchronous reset in the middle of a slot
    fill_pattern(3);
    model_slot(1'b1, 3);
    send_slot(3);
    repeat (3) tick();
    #2 rstn = 1'b0;
    #1;
    check("midreset m_valid", 64'(m_valid), 64'(0));
    check("midreset m_last", 64'(m_last), 64'(0));
    check("midreset frame_count", 64'(frame_count), 64'(0));
    check("midreset drop_count", 64'(drop_count), 64'(0));
    tick();
    rstn = 1'b1;
    model_reset();
    tick();
    fill_pattern(0);
    model_slot(1'b1, 0);
    send_slot(0);
    drain_compare("post reset");
    check("post reset frame_count", 64'(frame_count), 64'(m_fc));

    // Random slots, channel slips, enable drops and random backpressure
    rand_ready = 1'b1;
    for (int r = 0; r < 60; r++) begin
      en = ($urandom_range(0, 19) != 0);
      if (!m_synced) ch = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 36));
      else ch = ($urandom_range(0, 19) != 0) ? m_exp : int'($urandom_range(0, 40));
      enable = en;
      tick();
      fill_random();
      model_slot(en, ch);
      send_slot(ch);
      drain_compare($sformatf("rand%0d ch%0d", r, ch));
    end
    rand_ready = 1'b0;
    m_ready = 1'b1;
    enable = 1'b1;
    tick();
    check("rand seq_error", 64'(seq_error), 64'(m_seq));
    check("rand drop_count", 64'(drop_count), 64'(m_drop));
    check("rand overflow", 64'(overflow), 64'(m_ovf));
    check("rand frame_count", 64'(frame_count), 64'(m_fc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rhd_frame_packer.md
Name: rhd_frame_packer

Overview:
- Sits directly downstream of rhd_2048, which delivers one 32-lane × 16-bit sample set per SPI command slot.
- Each slot is tagged with the RHD channel index (0..FRAME_SLOTS-1).
- The block captures each slot into a one-deep holding buffer and checks channel sequencing.
- It serialises frames onto a 32-bit valid/ready stream: one header word per frame, then NUM_LANES/2 words per slot, with `m_last` on the final word of the frame.

Parameters:
- NUM_LANES, 32, MISO lanes per slot (A1..P2); must be even.
- FRAME_SLOTS, 35, slots per frame (32 amplifier channels + 3 aux); channel indices 0..FRAME_SLOTS-1.
- MAGIC, 16'hA5C3, header magic placed in header bits [31:16].

Ports:
- clk  in  1  system clock (112 MHz).
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  packing enable; low stops acceptance at the next slot boundary.
- s_valid  in  1  one-cycle pulse: slot data valid.
- s_channel  in  8  channel index of the slot.
- s_data  in  16*NUM_LANES  lane L occupies bits [16L+15:16L].
- m_data  out  32  stream word.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  final word of frame.
- overflow  out  1  sticky: slot dropped because the buffer was busy.
- seq_error  out  1  sticky: channel sequence violation.
- clear_flags  in  1  synchronous clear of the sticky flags and drop_count.
- drop_count  out  16  saturating count of dropped slots (overflow or sequence errors).
- frame_count  out  16  frames started; wraps at 65535→0.

Behaviour:
- Reset (async, rstn=0): state IDLE, synced=0, expected channel 0, all outputs 0, frame_count=0, drop_count=0.
- States: IDLE, HEADER, DATA.
- Acceptance, evaluated in IDLE only when s_valid=1:
  - enable=0: ignore the slot, no flag.
  - synced=0 and s_channel≠0: discard silently (waiting for frame start).
  - synced=0 and s_channel=0: set synced, load buffer, go to HEADER.
  - synced=1 and s_channel≠expected: set seq_error, increment drop_count, clear synced. If s_channel=0, resync immediately as above (the partial previous frame is left without `m_last`).
  - synced=1 and s_channel=expected: load buffer. Go to HEADER if the channel is 0, else DATA.
  - s_channel ≥ FRAME_SLOTS is always a sequence violation.
- s_valid while in HEADER or DATA: slot dropped, overflow=1, drop_count+1. The drop_count increment saturates at 16'hFFFF. The buffer is not overwritten.
- HEADER: m_data={MAGIC, frame_count}, m_valid=1. On the m_ready handshake, frame_count+1 and go to DATA with word index 0.
- DATA: word k (0..NUM_LANES/2-1) = {lane[2k+1], lane[2k]}, taken from the held buffer.
  - Each handshake advances k.
  - m_last=1 only on k=NUM_LANES/2-1 when the buffered channel is FRAME_SLOTS-1.
  - After the final word: expected = (channel+1) mod FRAME_SLOTS, then go to IDLE.
- Stream rules:
  - m_data, m_valid and m_last are registered and held stable while m_valid=1 and m_ready=0.
  - Zero bubble between words of a slot. One idle cycle between slots is allowed.
- Latency: s_valid at cycle T → first m_valid at T+1 (header or word 0).
- enable falling mid-slot: the current slot completes. Further slots are ignored and synced is cleared, so re-enable resyncs at channel 0.
- clear_flags in the same cycle as a new drop: the clear wins for the flags, and drop_count becomes 1.
- Width rule: drop_count saturates; frame_count wraps.

Decomposition:
- Shared package rhd_pkg holds:
  - the RHD_MAGIC, RHD_FRAME_SLOTS and RHD_NUM_LANES constants;
  - the state enum;
  - a lane-slice helper function.
- Natural sub-module: rhd_slot_buffer, the NUM_LANES×16 holding register with load, busy and word-select mux.

Test Plan:
1. Send channels 0..34 with lane L = 16'h0100*ch+L, m_ready=1 → 1 header 0xA5C30000, then 35×16 words; word0 of ch0 = 0x00010000; m_last only on the 561st word.
2. Hold m_ready=0 for 5 cycles mid-slot → m_data stable; no word lost or duplicated; sequence resumes.
3. Enable mid-frame so the first slot seen is ch 7 → ignored until ch 0; first output is a header with frame_count 0.
4. Sequence 0,1,3 → seq_error=1, drop_count=1, ch 3 not emitted. A later ch 0 resyncs and emits a header with frame_count 1.
5. Pulse s_valid 2 cycles after a slot starts with m_ready=0 → overflow=1, drop_count=1. The buffered slot still emits its correct 16 words.
6. Assert rstn=0 mid-DATA → m_valid=0 immediately and counters=0. The next ch 0 produces a header with frame_count 0.
